// File: rtl/rip_axi_port_arbiter.sv
// Two-port arbiter in front of the rip_axi_master line-transfer command interface.
// Only one transaction is in flight at a time. RIP_ARB_ROUND_ROBIN_EN enables round-robin tie-break.
module rip_axi_port_arbiter #(
   parameter int unsigned ADDR_WIDTH = 32,
   parameter int unsigned LINE_SIZE  = 4,
   localparam int unsigned LW        = LINE_SIZE * 8
) (
   input  logic                         clk,
   input  logic                         rstn,
   input  logic [1:0]                   req_valid,
   input  logic [1:0]                   req_we,
   input  logic [1:0][ADDR_WIDTH-1:0]   req_addr,
   input  logic [1:0][LW-1:0]           req_wdata,
   input  logic [1:0][LINE_SIZE-1:0]    req_wstrb,
   output logic [1:0]                   done,
   output logic [1:0][LW-1:0]           rdata,
   output logic [ADDR_WIDTH-1:0]        waddr,
   output logic [LW-1:0]                wdata,
   output logic [LINE_SIZE-1:0]         wstrb,
   output logic                         wvalid,
   input  logic                         wready,
   input  logic                         wdone,
   output logic [ADDR_WIDTH-1:0]        raddr,
   output logic                         rvalid,
   input  logic                         rready,
   input  logic                         rdone,
   input  logic [LW-1:0]                rdata_m
);

   typedef enum logic [2:0] {
      StIdle,
      StWCmd,
      StWWait,
      StRCmd,
      StRWait,
      StResp
   } state_e;

   state_e                   state_q, state_d;
   logic                     grant_q, grant_d;
   logic [ADDR_WIDTH-1:0]    addr_q, addr_d;
   logic [LW-1:0]            wdata_q, wdata_d;
   logic [LINE_SIZE-1:0]     wstrb_q, wstrb_d;
   logic [1:0][LW-1:0]       rdata_q, rdata_d;
   logic                     win;

`ifdef RIP_ARB_ROUND_ROBIN_EN
   logic last_grant_q, last_grant_d;

   // On a tie the port that was not served last goes first.
   always_comb begin
      if (&req_valid) win = ~last_grant_q;
      else            win = ~req_valid[0];
   end

   always_comb begin
      last_grant_d = last_grant_q;
      if (state_q == StResp) last_grant_d = grant_q;
   end

   always_ff @(posedge clk) begin
      if (!rstn) last_grant_q <= 1'b1;
      else       last_grant_q <= last_grant_d;
   end
`else
   // Fixed priority: port 0 whenever it is requesting.
   always_comb win = ~req_valid[0];
`endif

   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      wstrb_d = wstrb_q;
      rdata_d = rdata_q;
      unique case (state_q)
         StIdle: begin
            if (|req_valid) begin
               grant_d = win;
               addr_d  = req_addr[win];
               wdata_d = req_wdata[win];
               wstrb_d = req_wstrb[win];
               state_d = req_we[win] ? StWCmd : StRCmd;
            end
         end
         StWCmd:  if (wready) state_d = StWWait;
         StRCmd:  if (rready) state_d = StRWait;
         StWWait: if (wdone)  state_d = StResp;
         StRWait: begin
            if (rdone) begin
               rdata_d[grant_q] = rdata_m;
               state_d          = StResp;
            end
         end
         StResp:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         state_q <= StIdle;
         grant_q <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         wstrb_q <= '0;
         rdata_q <= '0;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         wstrb_q <= wstrb_d;
         rdata_q <= rdata_d;
      end
   end

   // Command fields are only driven while the matching valid is up.
   always_comb begin
      wvalid = (state_q == StWCmd);
      rvalid = (state_q == StRCmd);
      waddr  = wvalid ? addr_q : '0;
      wdata  = wvalid ? wdata_q : '0;
      wstrb  = wvalid ? wstrb_q : '0;
      raddr  = rvalid ? addr_q : '0;
      rdata  = rdata_q;
      done   = 2'b00;
      if (state_q == StResp) done = grant_q ? 2'b10 : 2'b01;
   end

endmodule

// File: tb/tb_rip_axi_port_arbiter.sv
// Directed, scoreboard-based bench for rip_axi_port_arbiter.
// Tie-break expectations follow RIP_ARB_ROUND_ROBIN_EN.
module tb_rip_axi_port_arbiter;

   localparam int AW = 32;
   localparam int LS = 4;
   localparam int LW = 32;

   logic                  clk = 1'b0;
   logic                  rstn;
   logic [1:0]            req_valid, req_we;
   logic [1:0][AW-1:0]    req_addr;
   logic [1:0][LW-1:0]    req_wdata;
   logic [1:0][LS-1:0]    req_wstrb;
   logic [1:0]            done;
   logic [1:0][LW-1:0]    rdata;
   logic [AW-1:0]         waddr, raddr;
   logic [LW-1:0]         wdata, rdata_m;
   logic [LS-1:0]         wstrb;
   logic                  wvalid, wready, wdone, rvalid, rready, rdone;

   rip_axi_port_arbiter #(.ADDR_WIDTH(AW), .LINE_SIZE(LS)) dut (
      .clk(clk), .rstn(rstn),
      .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr),
      .req_wdata(req_wdata), .req_wstrb(req_wstrb),
      .done(done), .rdata(rdata),
      .waddr(waddr), .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid),
      .wready(wready), .wdone(wdone),
      .raddr(raddr), .rvalid(rvalid), .rready(rready), .rdone(rdone),
      .rdata_m(rdata_m)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [1:0]    done;
      logic [LW-1:0] rd0;
      logic [LW-1:0] rd1;
   } exp_t;

   exp_t          sb[$];
   exp_t          mon_e;
   int            checks = 0;
   int            errors = 0;
   logic [LW-1:0] rd_m [2];
   logic          last_m;
   logic          g;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [1:0] oh(input logic p);
      return p ? 2'b10 : 2'b01;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input logic p, input logic we, input logic [AW-1:0] a,
                        input logic [LW-1:0] d, input logic [LS-1:0] s);
      req_we[p]    = we;
      req_addr[p]  = a;
      req_wdata[p] = d;
      req_wstrb[p] = s;
      req_valid[p] = 1'b1;
   endtask

   task automatic expect_done(input logic p);
      exp_t e;
      e.done = oh(p);
      e.rd0  = rd_m[0];
      e.rd1  = rd_m[1];
      sb.push_back(e);
   endtask

   task automatic wait_rvalid();
      int n = 0;
      while (!rvalid && n < 50) begin
         tick();
         n++;
      end
      chk("rvalid_timeout", 64'(rvalid), 64'(1));
   endtask

   // Requester drops its valid at the edge that ends the done cycle.
   task automatic wait_done(input logic p);
      int n = 0;
      while (!done[p] && n < 50) begin
         tick();
         n++;
      end
      chk("done_timeout", 64'(done[p]), 64'(1));
      tick();
      req_valid[p] = 1'b0;
      last_m       = p;
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_done"},   64'(done),     64'(0));
      chk({tag, "_wvalid"}, 64'(wvalid),   64'(0));
      chk({tag, "_rvalid"}, 64'(rvalid),   64'(0));
      chk({tag, "_waddr"},  64'(waddr),    64'(0));
      chk({tag, "_raddr"},  64'(raddr),    64'(0));
      chk({tag, "_wdata"},  64'(wdata),    64'(0));
      chk({tag, "_wstrb"},  64'(wstrb),    64'(0));
      chk({tag, "_rdata0"}, 64'(rdata[0]), 64'(0));
      chk({tag, "_rdata1"}, 64'(rdata[1]), 64'(0));
   endtask

   // Scoreboard: every done pulse must match the oldest expected completion.
   always @(negedge clk) begin
      if (rstn === 1'b1 && done !== 2'b00) begin
         if (sb.size() == 0) begin
            chk("unexpected_done", 64'(done), 64'(0));
         end else begin
            mon_e = sb.pop_front();
            chk("sb_done",   64'(done),     64'(mon_e.done));
            chk("sb_rdata0", 64'(rdata[0]), 64'(mon_e.rd0));
            chk("sb_rdata1", 64'(rdata[1]), 64'(mon_e.rd1));
         end
      end
   end

   initial begin
      rstn      = 1'b0;
      req_valid = '0;
      req_we    = '0;
      req_addr  = '0;
      req_wdata = '0;
      req_wstrb = '0;
      wready    = 1'b1;
      rready    = 1'b1;
      wdone     = 1'b0;
      rdone     = 1'b0;
      rdata_m   = '0;
      rd_m[0]   = '0;
      rd_m[1]   = '0;
      last_m    = 1'b1;
      g         = 1'b0;
      repeat (3) tick();
      chk_all_zero("reset");
      rstn = 1'b1;
      tick();

      // Port 0 read, rdone three cycles after accept.
      rd_m[0] = 32'hDEADBEEF;
      expect_done(1'b0);
      issue(1'b0, 1'b0, 32'h100, 32'h0, 4'h0);
      tick();
      chk("s1_rvalid", 64'(rvalid), 64'(1));
      chk("s1_raddr",  64'(raddr),  64'h100);
      chk("s1_wvalid", 64'(wvalid), 64'(0));
      tick();
      chk("s1_rvalid_drop", 64'(rvalid), 64'(0));
      tick();
      tick();
      rdone   = 1'b1;
      rdata_m = 32'hDEADBEEF;
      tick();
      rdone   = 1'b0;
      rdata_m = '0;
      chk("s1_done_latency", 64'(done), 64'(2'b01));
      wait_done(1'b0);

      // Port 1 write held off by wready for four cycles.
      wready = 1'b0;
      expect_done(1'b1);
      issue(1'b1, 1'b1, 32'h200, 32'h12345678, 4'b0011);
      tick();
      for (int i = 0; i < 4; i++) begin
         chk("s2_wvalid_hold", 64'(wvalid), 64'(1));
         chk("s2_waddr_hold",  64'(waddr),  64'h200);
         chk("s2_wstrb_hold",  64'(wstrb),  64'(4'b0011));
         chk("s2_wdata_hold",  64'(wdata),  64'h12345678);
         tick();
      end
      wready = 1'b1;
      chk("s2_wvalid_5th", 64'(wvalid), 64'(1));
      tick();
      chk("s2_wvalid_drop", 64'(wvalid), 64'(0));
      wdone = 1'b1;
      tick();
      wdone = 1'b0;
      chk("s2_done", 64'(done), 64'(2'b10));
      wait_done(1'b1);

      // Both ports keep reading continuously: every IDLE sees a tie.
      issue(1'b0, 1'b0, 32'h300, 32'h0, 4'h0);
      issue(1'b1, 1'b0, 32'h400, 32'h0, 4'h0);
      for (int i = 0; i < 4; i++) begin
`ifdef RIP_ARB_ROUND_ROBIN_EN
         g = ~last_m;
`else
         g = 1'b0;
`endif
         rd_m[g] = 32'hC0DE0000 + 32'(i);
         expect_done(g);
         wait_rvalid();
         chk("s3_raddr", 64'(raddr), g ? 64'h400 : 64'h300);
         tick();
         rdone   = 1'b1;
         rdata_m = 32'hC0DE0000 + 32'(i);
         tick();
         rdone   = 1'b0;
         rdata_m = '0;
         chk("s3_done", 64'(done), 64'(oh(g)));
         last_m = g;
         tick();
      end
      req_valid = '0;
      tick();

      // Reset while waiting for rdone, then a stray rdone.
      issue(1'b0, 1'b0, 32'h500, 32'h0, 4'h0);
      wait_rvalid();
      tick();
      chk("s4_in_rwait", 64'(rvalid), 64'(0));
      rstn      = 1'b0;
      req_valid = '0;
      tick();
      tick();
      chk_all_zero("s4_reset");
      rd_m[0] = '0;
      rd_m[1] = '0;
      last_m  = 1'b1;
      rstn    = 1'b1;
      rdone   = 1'b1;
      rdata_m = 32'hBAD0BAD0;
      tick();
      rdone   = 1'b0;
      rdata_m = '0;
      tick();
      tick();
      chk("s4_no_done",  64'(done),     64'(0));
      chk("s4_rdata0",   64'(rdata[0]), 64'(0));
      chk("s4_rvalid",   64'(rvalid),   64'(0));

      // Port 0 read, then port 1 write must leave rdata[0] alone.
      rd_m[0] = 32'hA5A5A5A5;
      expect_done(1'b0);
      issue(1'b0, 1'b0, 32'h600, 32'h0, 4'h0);
      tick();
      chk("s5_idle_rvalid", 64'(rvalid), 64'(1));
      tick();
      rdone   = 1'b1;
      rdata_m = 32'hA5A5A5A5;
      tick();
      rdone   = 1'b0;
      rdata_m = '0;
      wait_done(1'b0);
      expect_done(1'b1);
      issue(1'b1, 1'b1, 32'h700, 32'h55, 4'hF);
      tick();
      chk("s5_wvalid", 64'(wvalid), 64'(1));
      tick();
      wdone = 1'b1;
      tick();
      wdone = 1'b0;
      chk("s5_rdata0_held", 64'(rdata[0]), 64'hA5A5A5A5);
      wait_done(1'b1);

      repeat (5) tick();
      chk("sb_empty", 64'(sb.size()), 64'(0));
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
